tff_sync_counter: RTL and testbench

- Synchronous W-bit binary up/down counter built from toggle-flop cells; sits directly downstream of the toggle-flop stage and consumes its toggle behaviour.
- Bit i toggles when all lower bits are 1 (up) or all 0 (down).
- Free-run mode wraps around. One-shot mode stops at terminal count and flags completion.
- Used as a general event/timeout counter in the datapath.

---
 rtl/tff_cnt_pkg.sv | 16 +
 rtl/tff_sync_counter_tff_cell.sv | 34 +++
 rtl/tff_sync_counter.sv | 120 ++++++++++++
 tb/tb_tff_sync_counter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tff_cnt_pkg.sv
// Shared definitions for the toggle-flop based up/down counter.
//   state_e      : controller state (2-bit encoding)
//   MODE_FREE    : free-running, wraps at the ends of the range
//   MODE_ONESHOT : stops at terminal count and pulses done
package tff_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic MODE_FREE    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/tff_sync_counter_tff_cell.sv
// Single toggle flop with synchronous parallel load.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears the flop to 0
//   t_i    : toggle request for this edge
//   ld_i   : synchronous load, overrides the toggle
//   d_i    : load data
//   q_o    : flop output
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t_i,
  input  logic ld_i,
  input  logic d_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = ld_i ? d_i : (q_q ^ t_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/tff_sync_counter.sv
// W-bit synchronous up/down event/timeout counter built from toggle flops.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   start    : begin counting (taken in IDLE or DONE)
//   stop     : abort to IDLE from any state, wins over start
//   en       : qualifies each count step while running
//   mode     : 0 free-run (wrap), 1 one-shot (stop at terminal count)
//   up_dn    : 1 count up, 0 count down
//   load     : synchronous load of load_val, wins over counting
//   load_val : load data
//   q        : counter value (registered)
//   tc       : terminal count for the current direction (combinational)
//   busy     : high while running (registered)
//   done     : one-cycle pulse on one-shot completion (registered)
//
// state   | meaning
// IDLE    | stopped, waiting for start
// RUN     | counting on enabled edges
// DONE    | one-shot reached terminal count, q held
module tff_sync_counter
  import tff_cnt_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic         en,
  input  logic         mode,
  input  logic         up_dn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic         tc,
  output logic         busy,
  output logic         done
);

  state_e         state_q;
  logic           busy_q;
  logic           done_q;
  logic           running;
  logic           cnt_step;
  logic           term_hit;
  logic [W-1:0]   t;

  assign running = (state_q == ST_RUN);
  assign tc      = up_dn ? (&q) : ~(|q);

  // In one-shot mode the terminal edge holds q instead of wrapping.
  assign cnt_step = running & en & ~load & ((mode == MODE_FREE) | ~tc);
  assign term_hit = running & en & ~load & (mode == MODE_ONESHOT) & tc;

  // Ripple toggle chain: a bit flips when every lower bit is at the
  // carry (up) or borrow (down) value.
  always_comb begin
    t[0] = cnt_step;
    for (int i = 1; i < W; i++) begin
      t[i] = t[i-1] & (up_dn ? q[i-1] : ~q[i-1]);
    end
  end

  for (genvar g = 0; g < W; g++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .t_i   (t[g]),
      .ld_i  (load),
      .d_i   (load_val[g]),
      .q_o   (q[g])
    );
  end

  // Load never affects the state; it only suppresses the terminal check
  // through term_hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (term_hit) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_tff_sync_counter.sv
module tb_tff_sync_counter;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         en = 1'b0;
  logic         mode = 1'b0;
  logic         up_dn = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q;
  logic         tc;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  int m_q;
  int m_st;
  bit m_busy;
  bit m_done;

  tff_sync_counter #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .en       (en),
    .mode     (mode),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference ----------------
  function automatic bit f_tc(input int v, input bit dir);
    return dir ? (v == MAXV) : (v == 0);
  endfunction

  function automatic bit f_fin();
    return (m_st == S_RUN) && mode && en && !load && !stop && f_tc(m_q, up_dn);
  endfunction

  function automatic int f_q();
    if (load) return int'(load_val);
    if (m_st == S_RUN && en && !(mode && f_tc(m_q, up_dn)))
      return up_dn ? (m_q + 1) % (MAXV + 1) : (m_q + MAXV) % (MAXV + 1);
    return m_q;
  endfunction

  function automatic int f_st();
    if (stop) return S_IDLE;
    if (start && m_st != S_RUN) return S_RUN;
    if (f_fin()) return S_DONE;
    return m_st;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q    <= 0;
      m_st   <= S_IDLE;
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else begin
      m_q    <= f_q();
      m_st   <= f_st();
      m_busy <= (f_st() == S_RUN);
      m_done <= f_fin();
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("q_model", int'(q), m_q);
      check("tc_model", int'(tc), int'(f_tc(m_q, up_dn)));
      check("busy_model", int'(busy), int'(m_busy));
      check("done_model", int'(done), int'(m_done));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; load = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    model_on = 1'b1;

    // reset state
    check("rst_q", int'(q), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_tc_up", int'(tc), 0);

    // free-run up from 0
    mode = 1'b0; up_dn = 1'b1; en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("fr_start_busy", int'(busy), 1);
    check("fr_start_q", int'(q), 0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      check("fr_q", int'(q), k % 16);
      check("fr_tc", int'(tc), (k % 16 == 15) ? 1 : 0);
      check("fr_busy", int'(busy), 1);
      check("fr_done", int'(done), 0);
    end

    // asynchronous reset mid-count
    stop = 1'b1; en = 1'b0;
    tick();
    stop = 1'b0; start = 1'b1; en = 1'b1;
    load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0; start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("pre_rst_q", int'(q), 5);
    rst_n = 1'b0;
    #1;
    check("async_rst_q", int'(q), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_q", int'(q), 0);
    check("post_rst_busy", int'(busy), 0);

    // down count after load
    en = 1'b1; load = 1'b1; load_val = 4'd3;
    tick();
    check("ld3_q", int'(q), 3);
    load = 1'b0; up_dn = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("dn_start_q", int'(q), 3);
    begin
      int exp_dn [5] = '{2, 1, 0, 15, 14};
      foreach (exp_dn[k]) begin
        tick();
        check("dn_q", int'(q), exp_dn[k]);
        check("dn_tc", int'(tc), (exp_dn[k] == 0) ? 1 : 0);
      end
    end

    // en gating, stop, start&stop in IDLE
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("gate_q", int'(q), 14);
      check("gate_busy", int'(busy), 1);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", int'(busy), 0);
    check("stop_q", int'(q), 14);
    start = 1'b1; stop = 1'b1; en = 1'b1;
    tick();
    idle_inputs();
    check("startstop_busy", int'(busy), 0);
    tick();
    check("startstop_q", int'(q), 14);

    // one-shot up from 13
    up_dn = 1'b1; mode = 1'b1; load = 1'b1; load_val = 4'd13;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("os_q13", int'(q), 13);
    tick();
    check("os_q14", int'(q), 14);
    tick();
    check("os_q15", int'(q), 15);
    check("os_busy15", int'(busy), 1);
    check("os_done15", int'(done), 0);
    tick();
    check("os_term_q", int'(q), 15);
    check("os_term_done", int'(done), 1);
    check("os_term_busy", int'(busy), 0);
    tick();
    check("os_after_done", int'(done), 0);
    check("os_after_q", int'(q), 15);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("os_restart_busy", int'(busy), 1);
    check("os_restart_done", int'(done), 0);
    tick();
    check("os_immed_done", int'(done), 1);
    check("os_immed_busy", int'(busy), 0);
    check("os_immed_q", int'(q), 15);

    // load collision with a count step
    mode = 1'b0; load = 1'b1; load_val = 4'd7;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("col_q7", int'(q), 7);
    load = 1'b1; load_val = 4'd2;
    tick();
    load = 1'b0;
    check("col_q2", int'(q), 2);
    tick();
    check("col_q3", int'(q), 3);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      start    = ($urandom_range(0, 3) == 0);
      stop     = ($urandom_range(0, 19) == 0);
      en       = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 15) == 0);
      load_val = W'($urandom_range(0, MAXV));
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 31) == 0) up_dn = ~up_dn;
      if ($urandom_range(0, 499) == 0) pulse_reset();
      tick();
    end

    idle_inputs();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
